// File: rtl/mod_counter_pkg.sv
// Shared types and the next-count arithmetic for mod_counter.
// All arithmetic is done at 64 bits so one function serves every legal WIDTH.
package mod_counter_pkg;

    typedef enum logic {
        MODE_WRAP,
        MODE_SATURATE
    } mode_e;

    typedef struct packed {
        logic [63:0] value;
        logic        boundary;
    } count_next_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_STEP  = 1;

    // Sums use a 65-bit scratch width so cur+step never loses its carry.
    function automatic count_next_t next_count(
        input logic [63:0] cur,
        input logic [63:0] step,
        input logic [63:0] max,
        input logic        up,
        input mode_e       mode
    );
        logic [64:0] c;
        logic [64:0] s;
        logic [64:0] m;
        count_next_t r;
        c          = {1'b0, cur};
        s          = {1'b0, step};
        m          = {1'b0, max};
        r.value    = cur;
        r.boundary = 1'b0;
        if (up) begin
            if (c + s <= m) begin
                r.value = 64'(c + s);
            end else begin
                r.boundary = 1'b1;
                r.value    = (mode == MODE_WRAP) ? 64'(c + s - m - 65'd1) : max;
            end
        end else begin
            if (c >= s) begin
                r.value = 64'(c - s);
            end else begin
                r.boundary = 1'b1;
                r.value    = (mode == MODE_WRAP) ? 64'(c + m + 65'd1 - s) : 64'd0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that ends a period.
// Only instantiated when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic ld,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] div_p0;

    assign tick = en && (div_p0 == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_p0 <= '0;
        end else if (clr || ld) begin
            div_p0 <= '0;
        end else if (en) begin
            div_p0 <= (div_p0 == LAST) ? '0 : div_p0 + 16'd1;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down event counter with wrap or saturate, clear, load and TC/OVF flags.
// Define MOD_COUNTER_PRESCALE_EN to count only every PRESCALE-th enabled cycle.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int          WIDTH    = DEFAULT_WIDTH,
    parameter logic [63:0] INIT     = 64'd0,
    parameter logic [63:0] STEP     = 64'(DEFAULT_STEP),
    parameter logic [63:0] MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter bit          SATURATE = 1'b0,
    parameter int          PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    output logic [WIDTH-1:0] O,
    output logic             TC,
    output logic             OVF
);

    localparam mode_e            MODE   = SATURATE ? MODE_SATURATE : MODE_WRAP;
    localparam logic [WIDTH-1:0] MAX_W  = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("mod_counter: WIDTH must be 2..64");
        end
        if (MAX > ((64'd1 << WIDTH) - 64'd1) || INIT > MAX) begin : g_bad_range
            $error("mod_counter: MAX must fit WIDTH and INIT must not exceed MAX");
        end
        if (STEP < 64'd1 || STEP > MAX) begin : g_bad_step
            $error("mod_counter: STEP must be 1..MAX");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be 1..65535");
        end
    endgenerate

    logic             count_evt;
    logic [WIDTH-1:0] ld_val_clamped;
    count_next_t      nxt;
    logic             unused_hi;
    logic [WIDTH-1:0] count_p1;
    logic             tc_p1;
    logic             ovf_p1;

`ifdef MOD_COUNTER_PRESCALE_EN
    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (CLK),
        .rst  (ASYNCRESET),
        .en   (EN),
        .clr  (CLR),
        .ld   (LD),
        .tick (count_evt)
    );
`else
    assign count_evt = EN;
`endif

    assign ld_val_clamped = (LD_VAL > MAX_W) ? MAX_W : LD_VAL;

    always_comb begin
        nxt = next_count(64'(count_p1), STEP, MAX, UP, MODE);
    end

    // Result never exceeds MAX, so bits at and above WIDTH are always zero.
    assign unused_hi = ^(nxt.value >> WIDTH);

    // Stage p1: registered count and flags
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            count_p1 <= INIT_W;
            tc_p1    <= 1'b0;
            ovf_p1   <= 1'b0;
        end else if (CLR) begin
            count_p1 <= INIT_W;
            tc_p1    <= 1'b0;
            ovf_p1   <= 1'b0;
        end else if (LD) begin
            count_p1 <= ld_val_clamped;
            tc_p1    <= 1'b0;
        end else if (count_evt) begin
            count_p1 <= nxt.value[WIDTH-1:0];
            tc_p1    <= nxt.boundary;
            if (nxt.boundary) begin
                ovf_p1 <= 1'b1;
            end
        end else begin
            tc_p1 <= 1'b0;
        end
    end

    assign O   = count_p1;
    assign TC  = tc_p1;
    assign OVF = ovf_p1;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter: several parameterisations share one clock and reset.
// The prescaler scenario is built only when MOD_COUNTER_PRESCALE_EN is defined.
module tb_mod_counter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // d0: defaults (WIDTH 16, INIT 0, STEP 1, wrap)
    logic        d0_en, d0_up, d0_clr, d0_ld;
    logic [15:0] d0_ldv, d0_o;
    logic        d0_tc, d0_ovf;
    // d1: MAX 9, STEP 3, wrap
    logic        d1_en, d1_up, d1_clr, d1_ld;
    logic [15:0] d1_ldv, d1_o;
    logic        d1_tc, d1_ovf;
    // d2: saturate, STEP 2, INIT 5
    logic        d2_en, d2_up, d2_clr, d2_ld;
    logic [15:0] d2_ldv, d2_o;
    logic        d2_tc, d2_ovf;
    // d3: MAX 100, INIT 4, wrap
    logic        d3_en, d3_up, d3_clr, d3_ld;
    logic [15:0] d3_ldv, d3_o;
    logic        d3_tc, d3_ovf;

    mod_counter u_d0 (
        .CLK(clk), .ASYNCRESET(rst), .EN(d0_en), .UP(d0_up), .CLR(d0_clr), .LD(d0_ld),
        .LD_VAL(d0_ldv), .O(d0_o), .TC(d0_tc), .OVF(d0_ovf)
    );

    mod_counter #(.WIDTH(16), .INIT(0), .STEP(3), .MAX(9), .SATURATE(1'b0)) u_d1 (
        .CLK(clk), .ASYNCRESET(rst), .EN(d1_en), .UP(d1_up), .CLR(d1_clr), .LD(d1_ld),
        .LD_VAL(d1_ldv), .O(d1_o), .TC(d1_tc), .OVF(d1_ovf)
    );

    mod_counter #(.WIDTH(16), .INIT(5), .STEP(2), .SATURATE(1'b1)) u_d2 (
        .CLK(clk), .ASYNCRESET(rst), .EN(d2_en), .UP(d2_up), .CLR(d2_clr), .LD(d2_ld),
        .LD_VAL(d2_ldv), .O(d2_o), .TC(d2_tc), .OVF(d2_ovf)
    );

    mod_counter #(.WIDTH(16), .INIT(4), .STEP(1), .MAX(100), .SATURATE(1'b0)) u_d3 (
        .CLK(clk), .ASYNCRESET(rst), .EN(d3_en), .UP(d3_up), .CLR(d3_clr), .LD(d3_ld),
        .LD_VAL(d3_ldv), .O(d3_o), .TC(d3_tc), .OVF(d3_ovf)
    );

`ifdef MOD_COUNTER_PRESCALE_EN
    logic        d4_en, d4_up, d4_clr, d4_ld;
    logic [15:0] d4_ldv, d4_o;
    logic        d4_tc, d4_ovf;

    mod_counter #(.WIDTH(16), .PRESCALE(4)) u_d4 (
        .CLK(clk), .ASYNCRESET(rst), .EN(d4_en), .UP(d4_up), .CLR(d4_clr), .LD(d4_ld),
        .LD_VAL(d4_ldv), .O(d4_o), .TC(d4_tc), .OVF(d4_ovf)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({d0_o, d0_tc, d0_ovf} !== {16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_d0: got O=%0d TC=%0b OVF=%0b, expected O=0 TC=0 OVF=0", d0_o, d0_tc, d0_ovf);
        end
        checks++;
        if ({d2_o, d2_tc, d2_ovf} !== {16'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_d2: got O=%0d TC=%0b OVF=%0b, expected O=5 TC=0 OVF=0", d2_o, d2_tc, d2_ovf);
        end
        checks++;
        if (d3_o !== 16'd4) begin
            errors++;
            $display("FAIL reset_d3: got O=%0d, expected O=4", d3_o);
        end
    endtask

    task automatic test_free_run;
        d0_en = 1'b1;
        d0_up = 1'b1;
        tick(5);
        checks++;
        if ({d0_o, d0_tc, d0_ovf} !== {16'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL free_run_5: got O=%0d TC=%0b OVF=%0b, expected O=5 TC=0 OVF=0", d0_o, d0_tc, d0_ovf);
        end
    endtask

    task automatic test_async_reset;
        tick(37);
        checks++;
        if (d0_o !== 16'd42) begin
            errors++;
            $display("FAIL async_pre: got O=%0d, expected O=42", d0_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({d0_o, d0_tc, d0_ovf} !== {16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_immediate: got O=%0d TC=%0b OVF=%0b, expected O=0 TC=0 OVF=0", d0_o, d0_tc, d0_ovf);
        end
        #2 rst = 1'b0;
        tick(3);
        checks++;
        if (d0_o !== 16'd3) begin
            errors++;
            $display("FAIL async_resume: got O=%0d, expected O=3", d0_o);
        end
        d0_en = 1'b0;
    endtask

    task automatic test_wrap;
        logic [15:0] exp_o   [5] = '{16'd3, 16'd6, 16'd9, 16'd2, 16'd5};
        logic        exp_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        d1_en = 1'b1;
        d1_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if ({d1_o, d1_tc, d1_ovf} !== {exp_o[i], exp_tc[i], exp_ovf[i]}) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got O=%0d TC=%0b OVF=%0b, expected O=%0d TC=%0b OVF=%0b",
                         i, d1_o, d1_tc, d1_ovf, exp_o[i], exp_tc[i], exp_ovf[i]);
            end
        end
        d1_en = 1'b0;
    endtask

    task automatic test_saturate;
        logic [15:0] exp_o   [4] = '{16'd1, 16'd0, 16'd0, 16'd0};
        logic        exp_tc  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        exp_ovf [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        d2_ld  = 1'b1;
        d2_ldv = 16'd3;
        tick(1);
        checks++;
        if ({d2_o, d2_tc} !== {16'd3, 1'b0}) begin
            errors++;
            $display("FAIL sat_load: got O=%0d TC=%0b, expected O=3 TC=0", d2_o, d2_tc);
        end
        d2_ld = 1'b0;
        d2_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d2_en = (i < 3);
            tick(1);
            checks++;
            if ({d2_o, d2_tc, d2_ovf} !== {exp_o[i], exp_tc[i], exp_ovf[i]}) begin
                errors++;
                $display("FAIL sat_down[%0d]: got O=%0d TC=%0b OVF=%0b, expected O=%0d TC=%0b OVF=%0b",
                         i, d2_o, d2_tc, d2_ovf, exp_o[i], exp_tc[i], exp_ovf[i]);
            end
        end
        d2_clr = 1'b1;
        tick(1);
        d2_clr = 1'b0;
        checks++;
        if ({d2_o, d2_tc, d2_ovf} !== {16'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sat_clear: got O=%0d TC=%0b OVF=%0b, expected O=5 TC=0 OVF=0", d2_o, d2_tc, d2_ovf);
        end
    endtask

    task automatic test_priority;
        d3_en = 1'b1;
        d3_up = 1'b1;
        tick(1);
        checks++;
        if (d3_o !== 16'd5) begin
            errors++;
            $display("FAIL prio_count: got O=%0d, expected O=5", d3_o);
        end
        d3_clr = 1'b1;
        d3_ld  = 1'b1;
        d3_ldv = 16'd7;
        tick(1);
        checks++;
        if (d3_o !== 16'd4) begin
            errors++;
            $display("FAIL prio_clr_over_ld: got O=%0d, expected O=4", d3_o);
        end
        d3_clr = 1'b0;
        d3_ldv = 16'hFFFF;
        tick(1);
        checks++;
        if ({d3_o, d3_tc} !== {16'd100, 1'b0}) begin
            errors++;
            $display("FAIL prio_ld_clamp: got O=%0d TC=%0b, expected O=100 TC=0", d3_o, d3_tc);
        end
        d3_ld = 1'b0;
        tick(1);
        checks++;
        if ({d3_o, d3_tc, d3_ovf} !== {16'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL prio_wrap_max: got O=%0d TC=%0b OVF=%0b, expected O=0 TC=1 OVF=1", d3_o, d3_tc, d3_ovf);
        end
        d3_ld  = 1'b1;
        d3_ldv = 16'd0;
        tick(1);
        checks++;
        if ({d3_o, d3_tc, d3_ovf} !== {16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL prio_ld_keeps_ovf: got O=%0d TC=%0b OVF=%0b, expected O=0 TC=0 OVF=1", d3_o, d3_tc, d3_ovf);
        end
        d3_ld = 1'b0;
        d3_up = 1'b0;
        tick(1);
        checks++;
        if ({d3_o, d3_tc} !== {16'd100, 1'b1}) begin
            errors++;
            $display("FAIL down_wrap_zero: got O=%0d TC=%0b, expected O=100 TC=1", d3_o, d3_tc);
        end
        tick(1);
        checks++;
        if ({d3_o, d3_tc} !== {16'd99, 1'b0}) begin
            errors++;
            $display("FAIL down_after_wrap: got O=%0d TC=%0b, expected O=99 TC=0", d3_o, d3_tc);
        end
        d3_en = 1'b0;
    endtask

`ifdef MOD_COUNTER_PRESCALE_EN
    task automatic test_prescale;
        logic [15:0] exp_p [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        logic        en_p  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        d4_en = 1'b1;
        d4_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            checks++;
            if (d4_o !== 16'(k / 4)) begin
                errors++;
                $display("FAIL prescale_run[%0d]: got O=%0d, expected O=%0d", k, d4_o, k / 4);
            end
        end
        d4_en  = 1'b0;
        d4_clr = 1'b1;
        tick(1);
        d4_clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d4_en = en_p[k];
            tick(1);
            checks++;
            if (d4_o !== exp_p[k]) begin
                errors++;
                $display("FAIL prescale_pause[%0d]: got O=%0d, expected O=%0d", k, d4_o, exp_p[k]);
            end
        end
        d4_en = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        {d0_en, d0_up, d0_clr, d0_ld, d0_ldv} = '0;
        {d1_en, d1_up, d1_clr, d1_ld, d1_ldv} = '0;
        {d2_en, d2_up, d2_clr, d2_ld, d2_ldv} = '0;
        {d3_en, d3_up, d3_clr, d3_ld, d3_ldv} = '0;
`ifdef MOD_COUNTER_PRESCALE_EN
        {d4_en, d4_up, d4_clr, d4_ld, d4_ldv} = '0;
`endif
        #1;
        test_reset();
        #2 rst = 1'b0;
        test_free_run();
        test_async_reset();
        test_wrap();
        test_saturate();
        test_priority();
`ifdef MOD_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
